rr_arb2_pkt: RTL and testbench

- Two-source packet arbiter sitting directly upstream of the 2:1 data mux (mux2_1).
- Arbitrates between two valid/ready streams with round-robin fairness and locks the grant for a whole packet, until the beat with last=1 is accepted.
- Presents the winning beat on a registered output stage.
- Drives the registered select (sel) consumed by the downstream 2:1 mux, so sel never changes mid-packet.

---
 rtl/rr_arb2_pkt_pkg.sv | 29 ++
 rtl/rr_arb2_pkt_if.sv | 20 ++
 rtl/rr_arb2_pkt_out_reg_stage.sv | 38 +++
 rtl/rr_arb2_pkt.sv | 54 +++++
 tb/tb_rr_arb2_pkt.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb2_pkt_pkg.sv
// Shared constants and grant selection for the two-source packet arbiter.
// Source 0 wins the first contention after reset because last_src starts at 1.
package arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  localparam logic LAST_SRC_RST = 1'b1;

  // Locked states pin the grant. Idle picks whichever source is valid,
  // alternating on contention.
  function automatic logic pick(input logic [1:0] st, input logic v0,
                                input logic v1, input logic last_src);
    logic g;
    case (st)
      ST_LOCK0: g = 1'b0;
      ST_LOCK1: g = 1'b1;
      default: begin
        if (v0 && v1)  g = ~last_src;
        else if (v0)   g = 1'b0;
        else if (v1)   g = 1'b1;
        else           g = last_src;
      end
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2_pkt_if.sv
// Handshake bundle: two valid/ready input streams, one output stream and the mux select.
interface rr_arb2_pkt_if #(parameter int DATA_W = 8);
  logic              in0_valid, in0_last, in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid, in1_last, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sel;

  modport slave (
    input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_last, sel
  );

  modport master (
    output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_last, sel
  );
endinterface

// File: rtl/rr_arb2_pkt_out_reg_stage.sv
// Single-entry output register (valid/data/last/sel) with a combinational ready path.
module out_reg_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_last,
  input  logic              d_sel,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              sel,
  output logic              space
);

  assign space = !valid || ready;

  // sel only moves on a load, so the downstream mux never switches under a held beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
      sel   <= 1'b0;
    end else if (ld) begin
      valid <= 1'b1;
      data  <= d_data;
      last  <= d_last;
      sel   <= d_sel;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_arb2_pkt.sv
// Round-robin 2:1 packet arbiter.
// The grant is locked from the first beat until the last beat is accepted.
module rr_arb2_pkt
  import arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_arb2_pkt_if.slave   bus
);

  logic [1:0]        state;
  logic              last_src;
  logic              g, gv, gl, space, take;
  logic [DATA_W-1:0] gd;

  always_comb begin
    g  = pick(state, bus.in0_valid, bus.in1_valid, last_src);
    gv = g ? bus.in1_valid : bus.in0_valid;
    gd = g ? bus.in1_data  : bus.in0_data;
    gl = g ? bus.in1_last  : bus.in0_last;
  end

  assign take          = gv && space;
  assign bus.in0_ready = space && !g;
  assign bus.in1_ready = space &&  g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_src <= LAST_SRC_RST;
    end else if (take) begin
      last_src <= g;
      state    <= gl ? ST_IDLE : (g ? ST_LOCK1 : ST_LOCK0);
    end
  end

  out_reg_stage #(.DATA_W(DATA_W)) u_out (
    .clk    (clk),
    .rst    (rst),
    .ld     (take),
    .d_data (gd),
    .d_last (gl),
    .d_sel  (g),
    .ready  (bus.out_ready),
    .valid  (bus.out_valid),
    .data   (bus.out_data),
    .last   (bus.out_last),
    .sel    (bus.sel),
    .space  (space)
  );

endmodule

// File: tb/tb_rr_arb2_pkt.sv
// Directed bench for rr_arb2_pkt. Expected beats are queued as they are accepted
// and are checked in order as they leave the output register.
module tb_rr_arb2_pkt;

  typedef struct packed {logic sel; logic last; logic [7:0] data;} beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t q[$];

  rr_arb2_pkt_if #(.DATA_W(8)) bus();

  rr_arb2_pkt #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic s, input logic l, input logic [7:0] d);
    beat_t b;
    b.sel = s; b.last = l; b.data = d;
    q.push_back(b);
  endtask

  // Called at the negedge: consume a beat if it leaves this cycle, then advance
  // to just after the next rising edge.
  task automatic tick();
    beat_t obs, exp;
    if (bus.out_valid && bus.out_ready) begin
      obs = {bus.sel, bus.out_last, bus.out_data};
      n_cmp++;
      assert (q.size() > 0) else begin
        n_bad++;
        $error("FAIL unexpected_beat: got %0h expected none", obs);
      end
      if (q.size() > 0) begin
        exp = q.pop_front();
        chk("beat", {22'b0, obs}, {22'b0, exp});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic src0(input logic v, input logic [7:0] d, input logic l);
    bus.in0_valid = v; bus.in0_data = d; bus.in0_last = l;
  endtask

  task automatic src1(input logic v, input logic [7:0] d, input logic l);
    bus.in1_valid = v; bus.in1_data = d; bus.in1_last = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src0(1'b0, 8'h00, 1'b0);
    src1(1'b0, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] i0, i1;
    logic       eg;

    rst = 1'b1;
    src0(1'b0, 8'h00, 1'b0);
    src1(1'b0, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid_async", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_last",  bus.out_last,  0);
    chk("rst_sel",       bus.sel,       0);
    tick();

    // single beat from source 0
    src0(1'b1, 8'h11, 1'b1);
    @(negedge clk);
    chk("t1_in0_ready", bus.in0_ready, 1);
    chk("t1_in1_ready", bus.in1_ready, 0);
    push(1'b0, 1'b1, 8'h11);
    tick();
    src0(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_data",  bus.out_data,  32'h11);
    chk("t1_sel",       bus.sel,       0);
    chk("t1_in1_ready_after", bus.in1_ready, 0);
    tick();

    // alternating single-beat packets from both sources
    do_reset();
    i0 = 8'hA0; i1 = 8'hB0; eg = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src0(1'b1, i0, 1'b1);
      src1(1'b1, i1, 1'b1);
      @(negedge clk);
      if (k > 0) chk("t2_no_bubble", bus.out_valid, 1);
      chk("t2_in0_ready", bus.in0_ready, {31'b0, !eg});
      chk("t2_in1_ready", bus.in1_ready, {31'b0, eg});
      push(eg, 1'b1, eg ? i1 : i0);
      if (eg) i1++; else i0++;
      eg = ~eg;
      tick();
    end
    src0(1'b0, 8'h00, 1'b0);
    src1(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t2_tail_valid", bus.out_valid, 1);
    tick();

    // 3-beat packet from source 0 holds off source 1
    src1(1'b1, 8'hC0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      src0(1'b1, 8'h01 + 8'(k), k == 2);
      @(negedge clk);
      chk("t3_in0_ready", bus.in0_ready, 1);
      chk("t3_in1_ready", bus.in1_ready, 0);
      push(1'b0, k == 2, 8'h01 + 8'(k));
      tick();
    end
    src0(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t3_in1_ready_after", bus.in1_ready, 1);
    push(1'b1, 1'b1, 8'hC0);
    tick();
    src1(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    tick();

    // source 0 stalls mid-packet; lock holds
    src1(1'b1, 8'hD0, 1'b1);
    src0(1'b1, 8'h04, 1'b0);
    @(negedge clk);
    chk("t4_in1_ready_a", bus.in1_ready, 0);
    push(1'b0, 1'b0, 8'h04);
    tick();
    src0(1'b1, 8'h05, 1'b0);
    @(negedge clk);
    chk("t4_in1_ready_b", bus.in1_ready, 0);
    push(1'b0, 1'b0, 8'h05);
    tick();
    src0(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_gap_in1_ready", bus.in1_ready, 0);
      chk("t4_gap_in0_ready", bus.in0_ready, 1);
      tick();
    end
    src0(1'b1, 8'h06, 1'b1);
    @(negedge clk);
    chk("t4_in1_ready_c", bus.in1_ready, 0);
    push(1'b0, 1'b1, 8'h06);
    tick();
    src0(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t4_in1_ready_after", bus.in1_ready, 1);
    push(1'b1, 1'b1, 8'hD0);
    tick();
    src1(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    tick();

    // backpressure
    src0(1'b1, 8'h21, 1'b1);
    @(negedge clk);
    chk("t5_in0_ready", bus.in0_ready, 1);
    push(1'b0, 1'b1, 8'h21);
    tick();
    src0(1'b1, 8'h22, 1'b1);
    src1(1'b1, 8'hE0, 1'b1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.out_valid, 1);
      chk("t5_hold_data",  bus.out_data,  32'h21);
      chk("t5_hold_last",  bus.out_last,  1);
      chk("t5_hold_sel",   bus.sel,       0);
      chk("t5_in0_ready",  bus.in0_ready, 0);
      chk("t5_in1_ready",  bus.in1_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_resume_in1", bus.in1_ready, 1);
    chk("t5_resume_in0", bus.in0_ready, 0);
    push(1'b1, 1'b1, 8'hE0);
    tick();
    src1(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_in0_ready_b", bus.in0_ready, 1);
    push(1'b0, 1'b1, 8'h22);
    tick();
    src0(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    tick();

    // async reset mid-packet
    src0(1'b1, 8'h31, 1'b0);
    @(negedge clk);
    push(1'b0, 1'b0, 8'h31);
    tick();
    src0(1'b1, 8'h32, 1'b0);
    @(negedge clk);
    push(1'b0, 1'b0, 8'h32);
    tick();
    rst = 1'b1;
    src0(1'b0, 8'h00, 1'b0);
    #1;
    chk("t6_async_clear", bus.out_valid, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    src0(1'b1, 8'h40, 1'b1);
    src1(1'b1, 8'h50, 1'b1);
    @(negedge clk);
    chk("t6_in0_ready", bus.in0_ready, 1);
    chk("t6_in1_ready", bus.in1_ready, 0);
    push(1'b0, 1'b1, 8'h40);
    tick();
    src0(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t6_in1_ready_b", bus.in1_ready, 1);
    push(1'b1, 1'b1, 8'h50);
    tick();
    src1(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tick();
    end
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
